// File: rtl/dma_fetch_responder.sv
// dma_fetch_responder
// Responder side of the DMA chunk-fetch handshake. Accepts one fetch request
// (source address, destination address, length in dwords), issues a single
// burst read to the memory port, writes every returned dword into video BRAM
// and pulses ack_fetch_data once the last dword has been written.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   fetch_data          request level from the descriptor processor
//   read_from           source byte address (dword-aligned)
//   write_to            destination BRAM byte address (dword-aligned)
//   length_data         dwords requested (clamped to PKT_LENGTH)
//   ack_fetch_data      one-cycle pulse: request fully written
//   mem_req_*           burst read request (valid/ready, address, length)
//   mem_rsp_*           read data beats, no backpressure
//   dma_data            BRAM write data
//   videomem_addr/_we   BRAM write byte address / write enable
//   busy                FSM not idle
//   len_err             sticky: an over-length request was seen
module dma_fetch_responder #(
    parameter int unsigned PKT_LENGTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_data,
    input  logic [15:0] read_from,
    input  logic [17:0] write_to,
    input  logic [15:0] length_data,
    output logic        ack_fetch_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [15:0] mem_req_addr,
    output logic [3:0]  mem_req_len,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic [31:0] dma_data,
    output logic [17:0] videomem_addr,
    output logic        videomem_we,
    output logic        busy,
    output logic        len_err
);

    localparam int unsigned LEN_W  = 4;
    localparam int unsigned ADDR_W = 18;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_RECV    = 3'd2;
    localparam logic [2:0] ST_ACK     = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [LEN_W-1:0]  beats_q, beats_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              ack_q, ack_d;
    logic              req_valid_q, req_valid_d;
    logic [15:0]       req_addr_q, req_addr_d;
    logic [LEN_W-1:0]  req_len_q, req_len_d;
    logic [31:0]       dma_data_q, dma_data_d;
    logic [ADDR_W-1:0] vm_addr_q, vm_addr_d;
    logic              vm_we_q, vm_we_d;
    logic              busy_q, busy_d;
    logic              len_err_q, len_err_d;

    logic              over_len;
    logic [LEN_W-1:0]  eff_len;

    // Clamp the requested length; req_len_q doubles as the latched eff_len.
    assign over_len = (length_data > 16'(PKT_LENGTH));
    assign eff_len  = over_len ? LEN_W'(PKT_LENGTH) : length_data[LEN_W-1:0];

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beats_q     <= '0;
            wr_ptr_q    <= '0;
            ack_q       <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_len_q   <= '0;
            dma_data_q  <= '0;
            vm_addr_q   <= '0;
            vm_we_q     <= 1'b0;
            busy_q      <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beats_q     <= beats_d;
            wr_ptr_q    <= wr_ptr_d;
            ack_q       <= ack_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_len_q   <= req_len_d;
            dma_data_q  <= dma_data_d;
            vm_addr_q   <= vm_addr_d;
            vm_we_q     <= vm_we_d;
            busy_q      <= busy_d;
            len_err_q   <= len_err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        beats_d     = beats_q;
        wr_ptr_d    = wr_ptr_q;
        ack_d       = 1'b0;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_len_d   = req_len_q;
        dma_data_d  = dma_data_q;
        vm_addr_d   = vm_addr_q;
        vm_we_d     = 1'b0;
        len_err_d   = len_err_q;

        case (state_q)
            ST_IDLE: begin
                if (fetch_data) begin
                    req_addr_d = read_from;
                    wr_ptr_d   = write_to;
                    req_len_d  = eff_len;
                    beats_d    = '0;
                    if (over_len) begin
                        len_err_d = 1'b1;
                    end
                    if (eff_len == '0) begin
                        state_d = ST_ACK;
                        ack_d   = 1'b1;
                    end else begin
                        state_d     = ST_ISSUE;
                        req_valid_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = ST_RECV;
                end
            end
            ST_RECV: begin
                if (mem_rsp_valid) begin
                    dma_data_d = mem_rsp_data;
                    vm_addr_d  = wr_ptr_q;
                    vm_we_d    = 1'b1;
                    wr_ptr_d   = wr_ptr_q + ADDR_W'(4);
                    beats_d    = beats_q + LEN_W'(1);
                    // Ack is raised alongside the final write
                    if (beats_d == req_len_q) begin
                        state_d = ST_ACK;
                        ack_d   = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Requester's level may still be high after ack; wait it out
                if (!fetch_data) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign ack_fetch_data = ack_q;
    assign mem_req_valid  = req_valid_q;
    assign mem_req_addr   = req_addr_q;
    assign mem_req_len    = req_len_q;
    assign dma_data       = dma_data_q;
    assign videomem_addr  = vm_addr_q;
    assign videomem_we    = vm_we_q;
    assign busy           = busy_q;
    assign len_err        = len_err_q;

endmodule

// File: tb/tb_dma_fetch_responder.sv
// Directed bench for dma_fetch_responder: a table of requests with
// hand-computed expectations plus a mid-burst reset sequence.
module tb_dma_fetch_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_data;
    logic [15:0] read_from;
    logic [17:0] write_to;
    logic [15:0] length_data;
    logic        ack_fetch_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [15:0] mem_req_addr;
    logic [3:0]  mem_req_len;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [31:0] dma_data;
    logic [17:0] videomem_addr;
    logic        videomem_we;
    logic        busy;
    logic        len_err;

    always #5 clk = ~clk;

    dma_fetch_responder #(.PKT_LENGTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_data     (fetch_data),
        .read_from      (read_from),
        .write_to       (write_to),
        .length_data    (length_data),
        .ack_fetch_data (ack_fetch_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_len    (mem_req_len),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .dma_data       (dma_data),
        .videomem_addr  (videomem_addr),
        .videomem_we    (videomem_we),
        .busy           (busy),
        .len_err        (len_err)
    );

    typedef struct {
        logic [15:0] rf;
        logic [17:0] wt;
        logic [15:0] len;
        int          rdy_delay;
        int          gap;
        int          hold;
        logic [31:0] dbase;
        logic [3:0]  exp_len;
        logic        exp_err;
        logic        stray;
    } vec_t;

    vec_t vecs[6];

    int n_pass  = 0;
    int n_total = 0;

    // Monitor: log BRAM writes, ack pulses and request-valid cycles mid-cycle
    logic [17:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          ack_cnt   = 0;
    int          valid_cnt = 0;

    always @(negedge clk) begin
        if (videomem_we === 1'b1) begin
            wr_addr_q.push_back(videomem_addr);
            wr_data_q.push_back(dma_data);
        end
        if (ack_fetch_data === 1'b1) ack_cnt++;
        if (mem_req_valid === 1'b1) valid_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_ack"},   32'(ack_fetch_data), 32'd0);
        chk({p, "_valid"}, 32'(mem_req_valid),  32'd0);
        chk({p, "_raddr"}, 32'(mem_req_addr),   32'd0);
        chk({p, "_rlen"},  32'(mem_req_len),    32'd0);
        chk({p, "_data"},  dma_data,            32'd0);
        chk({p, "_waddr"}, 32'(videomem_addr),  32'd0);
        chk({p, "_we"},    32'(videomem_we),    32'd0);
        chk({p, "_busy"},  32'(busy),           32'd0);
        chk({p, "_lerr"},  32'(len_err),        32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int    wb;
        int    ab;
        int    vb;
        int    nw;
        logic  stable;
        string p;
        p  = $sformatf("v%0d", id);
        wb = wr_addr_q.size();
        ab = ack_cnt;
        vb = valid_cnt;

        read_from   = v.rf;
        write_to    = v.wt;
        length_data = v.len;
        fetch_data  = 1'b1;
        step();
        chk({p, "_busy_accept"}, 32'(busy), 32'd1);
        chk({p, "_len_err"}, 32'(len_err), 32'(v.exp_err));
        // Field changes after the latch must be ignored
        read_from   = ~v.rf;
        write_to    = ~v.wt;
        length_data = 16'd1;

        if (v.exp_len == 4'd0) begin
            chk({p, "_zero_ack"}, 32'(ack_fetch_data), 32'd1);
            chk({p, "_zero_novalid"}, 32'(mem_req_valid), 32'd0);
        end else begin
            chk({p, "_req_valid"}, 32'(mem_req_valid), 32'd1);
            chk({p, "_req_addr"}, 32'(mem_req_addr), 32'(v.rf));
            chk({p, "_req_len"}, 32'(mem_req_len), 32'(v.exp_len));
            stable = 1'b1;
            for (int i = 0; i < v.rdy_delay; i++) begin
                mem_rsp_valid = v.stray;
                mem_rsp_data  = 32'hDEAD_BEEF;
                step();
                if (!(mem_req_valid === 1'b1 && mem_req_addr === v.rf &&
                      mem_req_len === v.exp_len && busy === 1'b1)) stable = 1'b0;
            end
            mem_rsp_valid = 1'b0;
            if (v.rdy_delay > 0) chk({p, "_stall_stable"}, 32'(stable), 32'd1);
            mem_req_ready = 1'b1;
            step();
            mem_req_ready = 1'b0;
            chk({p, "_valid_drop"}, 32'(mem_req_valid), 32'd0);
            for (int i = 0; i < int'(v.exp_len); i++) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = v.dbase + 32'(i);
                step();
                mem_rsp_valid = 1'b0;
                if (i != int'(v.exp_len) - 1) begin
                    for (int g = 0; g < v.gap; g++) step();
                end
            end
            chk({p, "_ack_last"}, 32'(ack_fetch_data), 32'd1);
            chk({p, "_we_last"}, 32'(videomem_we), 32'd1);
            chk({p, "_addr_last"}, 32'(videomem_addr),
                32'(18'(v.wt + 18'(4 * (int'(v.exp_len) - 1)))));
            chk({p, "_data_last"}, dma_data, v.dbase + 32'(v.exp_len) - 32'd1);
        end

        fetch_data = (v.hold > 0);
        step();
        chk({p, "_ack_single"}, 32'(ack_fetch_data), 32'd0);
        chk({p, "_busy_release"}, 32'(busy), 32'd1);
        for (int h = 1; h < v.hold; h++) step();
        fetch_data = 1'b0;
        step();
        step();
        chk({p, "_busy_idle"}, 32'(busy), 32'd0);

        // Stray beats in IDLE must not write
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_BAD0;
        step();
        step();
        mem_rsp_valid = 1'b0;
        step();

        nw = wr_addr_q.size() - wb;
        chk({p, "_write_count"}, 32'(nw), 32'(v.exp_len));
        for (int i = 0; i < int'(v.exp_len) && i < nw; i++) begin
            chk($sformatf("%s_waddr%0d", p, i), 32'(wr_addr_q[wb + i]),
                32'(18'(v.wt + 18'(4 * i))));
            chk($sformatf("%s_wdata%0d", p, i), wr_data_q[wb + i], v.dbase + 32'(i));
        end
        chk({p, "_ack_count"}, 32'(ack_cnt - ab), 32'd1);
        if (v.exp_len == 4'd0) chk({p, "_valid_cycles"}, 32'(valid_cnt - vb), 32'd0);
        else chk({p, "_valid_cycles"}, 32'(valid_cnt - vb), 32'(v.rdy_delay + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wb;
        //           rf        wt         len  rdy gap hold dbase           exp   err   stray
        vecs[0] = '{16'h0100, 18'h00200, 16'd8,  0, 0, 0, 32'h0000_00A0, 4'd8, 1'b0, 1'b0};
        vecs[1] = '{16'h0340, 18'h01000, 16'd3,  5, 2, 0, 32'h1000_0000, 4'd3, 1'b0, 1'b1};
        vecs[2] = '{16'h0500, 18'h02000, 16'd0,  0, 0, 2, 32'h0000_0000, 4'd0, 1'b0, 1'b0};
        vecs[3] = '{16'hFFF0, 18'h3FFF8, 16'd20, 1, 0, 0, 32'hC0DE_0000, 4'd8, 1'b1, 1'b0};
        vecs[4] = '{16'h0010, 18'h00040, 16'd5,  0, 1, 1, 32'h5555_0000, 4'd5, 1'b1, 1'b0};
        vecs[5] = '{16'h0800, 18'h10000, 16'd4,  2, 0, 0, 32'h7700_0000, 4'd4, 1'b0, 1'b0};

        rst           = 1'b1;
        fetch_data    = 1'b0;
        read_from     = '0;
        write_to      = '0;
        length_data   = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        step();
        step();
        chk_zero("reset");
        rst = 1'b0;
        step();

        for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

        // Reset after 4 of 8 beats
        read_from   = 16'h0200;
        write_to    = 18'h00300;
        length_data = 16'd8;
        fetch_data  = 1'b1;
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hE000_0000 + 32'(i);
            step();
        end
        rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        wb = wr_addr_q.size();
        fetch_data = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hE000_0010 + 32'(i);
            step();
        end
        mem_rsp_valid = 1'b0;
        step();
        step();
        chk("rst_mid_no_writes", 32'(wr_addr_q.size() - wb), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);

        run_vec(vecs[5], 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dma_fetch_responder.md
# dma_fetch_responder

Responder side of the DMA chunk-fetch handshake. It accepts one fetch request at a time: source byte address, destination byte address and a length of 1–8 dwords. It issues a single burst read to the cache/memory port and writes each returned dword into video BRAM. It pulses the acknowledge once the last dword has been written. It sits between the descriptor processor (the requester) and the memory port / video BRAM write port.

## Interface
- PKT_LENGTH, 8, maximum dwords per request; larger lengths are clamped to this value.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- fetch_data  in  1  request level; held high by the requester until it sees ack
- read_from  in  16  source byte address (dword-aligned)
- write_to  in  18  destination BRAM byte address (dword-aligned)
- length_data  in  16  dwords requested
- ack_fetch_data  out  1  one-cycle pulse: request fully written
- mem_req_valid  out  1  burst read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  16  burst start byte address
- mem_req_len  out  4  burst length in dwords, 1..8
- mem_rsp_valid  in  1  read data beat valid (no backpressure)
- mem_rsp_data  in  32  read data beat
- dma_data  out  32  BRAM write data
- videomem_addr  out  18  BRAM write byte address
- videomem_we  out  1  BRAM write enable
- busy  out  1  state != IDLE
- len_err  out  1  sticky: a request with length > PKT_LENGTH was seen; cleared only by rst

## Operation
- States: IDLE, ISSUE, RECV, ACK, RELEASE.
- IDLE, fetch_data=1:
  - Latch read_from, write_to and eff_len = min(length_data, PKT_LENGTH).
  - If length_data > PKT_LENGTH, set len_err.
  - eff_len=0 → go to ACK (no memory access); otherwise → ISSUE.
- ISSUE:
  - mem_req_valid=1, mem_req_addr=latched read_from, mem_req_len=eff_len[3:0].
  - Valid and all request fields stay stable until mem_req_ready; on ready → RECV.
- RECV:
  - Each mem_rsp_valid beat: dma_data<=mem_rsp_data, videomem_addr<=wr_ptr, videomem_we<=1 (next cycle only).
  - After each beat: wr_ptr += 4, beats += 1.
  - When beats reaches eff_len → ACK.
- ACK: ack_fetch_data=1 for exactly one cycle → RELEASE.
- RELEASE:
  - Wait until fetch_data=0 → IDLE.
  - Guarantees no duplicate accept while the requester's registered request is still high after ack.
- Address arithmetic:
  - wr_ptr is 18-bit and wraps modulo 2^18.
  - Burst address is not split or checked for 16-bit overflow.
- mem_rsp_valid outside RECV (IDLE, ISSUE, ACK, RELEASE) is ignored; no BRAM write.
- Request field changes after latch are ignored until the next IDLE accept.

## Timing
- Reset values:
  - Outputs: ack_fetch_data=0, mem_req_valid=0, mem_req_addr=0, mem_req_len=0, dma_data=0, videomem_addr=0, videomem_we=0, busy=0, len_err=0.
  - Internal: state=IDLE, beats=0, wr_ptr=0.
- Request fetch_data=1 sampled in IDLE at edge T:
  - mem_req_valid=1 from T+1.
  - Zero-length request: ack_fetch_data=1 in T+1.
- Request handshake completes at the edge where mem_req_valid & mem_req_ready; mem_req_valid=0 in the next cycle.
- Response beats may arrive in the same cycle as the request handshake. Such beats are not counted (state still ISSUE); the memory port must not do this.
- Beat at edge t → videomem_we=1 in cycle t+1 only; back-to-back beats give back-to-back writes.
- Final beat at edge t_last:
  - Write visible in t_last+1.
  - ack_fetch_data=1 in t_last+1 (state ACK).
  - ack=0 from t_last+2.
- Earliest re-accept is the cycle after fetch_data is observed low in RELEASE.
- rst mid-burst:
  - Immediate return to IDLE with all outputs at reset values.
  - Beats still in flight after reset are dropped.

## Test plan
- Full chunk: read_from=0x0100, write_to=0x00200, length 8; memory ready immediately, 8 consecutive beats 0xA0..0xA7 → 8 writes at addrs 0x00200..0x0021C (step 4), data 0xA0..0xA7; mem_req_len=8; single ack pulse in the cycle after the 8th write is issued.
- Short chunk with stalls: length 3, mem_req_ready held low 5 cycles, beats with 2-cycle gaps → request fields stable during stall, exactly 3 writes, ack after third write, busy=1 throughout.
- Zero length: length 0 → no mem_req_valid, ack_fetch_data at T+1, then RELEASE until fetch_data drops.
- Clamp / wrap: length 20, write_to=0x3FFF8 → len_err=1 (stays 1), mem_req_len=8, write addrs 0x3FFF8, 0x3FFFC, 0x00000..0x00014.
- Handshake hygiene: requester keeps fetch_data high 1 cycle past ack, then a second request 2 cycles later → only one accept for the first, second request served normally; stray mem_rsp_valid in IDLE produces no write.
- Reset mid-burst: assert rst after 4 of 8 beats → all outputs zero immediately; remaining beats produce no writes; new request afterwards completes normally.
